// File: rtl/unsigned_restoring_divider_16.sv
// Radix-2 restoring unsigned divider: one quotient bit per clock, start/busy/done handshake.
// Latency WIDTH+1 edges from accept to done; UNSIGNED_DIVIDER_EARLY_OUT_EN finishes trivial cases in 1.
// start is ignored while RUN; a start seen in DONE is accepted back-to-back.
module unsigned_restoring_divider_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] pr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvsr;

    // After a restore the partial remainder is below the divisor, so only the
    // shifted value needs the extra bit; the stored value fits in WIDTH bits.
    logic [WIDTH:0]   pr_sh;
    logic [WIDTH-1:0] diff;
    logic             take;

    assign pr_sh = {pr, q[WIDTH-1]};
    assign take  = (pr_sh >= {1'b0, dvsr});
    assign diff  = pr_sh[WIDTH-1:0] - dvsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            count       <= '0;
            pr          <= '0;
            q           <= '0;
            dvsr        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        dvsr  <= divisor;
                        q     <= dividend;
                        pr    <= '0;
                        count <= CW'(WIDTH - 1);
                        state <= RUN;
`ifdef UNSIGNED_DIVIDER_EARLY_OUT_EN
                        if (divisor == '0 || dividend < divisor) begin
                            q     <= (divisor == '0) ? '1 : '0;
                            pr    <= dividend;
                            state <= DONE;
                        end
`endif
                    end
                end
                RUN: begin
                    busy <= 1'b1;
                    done <= 1'b0;
                    pr   <= take ? diff : pr_sh[WIDTH-1:0];
                    q    <= {q[WIDTH-2:0], take};
                    if (count == '0)
                        state <= DONE;
                    else
                        count <= count - 1'b1;
                end
                DONE: begin
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    quotient    <= q;
                    remainder   <= pr;
                    div_by_zero <= (dvsr == '0);
                    if (start) begin
                        dvsr  <= divisor;
                        q     <= dividend;
                        pr    <= '0;
                        count <= CW'(WIDTH - 1);
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_unsigned_restoring_divider_16.sv
// Scoreboard bench for unsigned_restoring_divider_16: expectations queued at accept, checked on done.
module tb_unsigned_restoring_divider_16;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];

    unsigned_restoring_divider_16 #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int exp_lat(input logic [15:0] a, input logic [15:0] b);
`ifdef UNSIGNED_DIVIDER_EARLY_OUT_EN
        if (b == 16'd0 || a < b) return 1;
`endif
        return 17;
    endfunction

    task automatic push_exp(input logic [15:0] a, input logic [15:0] b, input int acc);
        exp_t e;
        e.q   = (b == 16'd0) ? 16'hFFFF : a / b;
        e.r   = (b == 16'd0) ? a : a % b;
        e.dz  = (b == 16'd0);
        e.acc = acc;
        e.lat = exp_lat(a, b);
        sb.push_back(e);
    endtask

    // Result checker: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            chk("busy_with_done", {31'd0, busy}, 32'd0);
            chk("done_expected", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", {16'd0, quotient}, {16'd0, e.q});
                chk("remainder", {16'd0, remainder}, {16'd0, e.r});
                chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
                chk("latency", cyc - e.acc, e.lat);
            end
        end
    end

    task automatic wait_done(output logic saw_busy);
        saw_busy = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy === 1'b1) saw_busy = 1'b1;
            if (done === 1'b1) return;
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    // Called at a negedge where the DUT can accept; returns at the negedge showing done.
    task automatic do_div(input logic [15:0] a, input logic [15:0] b, output logic saw_busy);
        logic sb_tmp;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        push_exp(a, b, cyc + 1);
        @(negedge clk);
        start    = 1'b0;
        saw_busy = (busy === 1'b1);
        wait_done(sb_tmp);
        saw_busy = saw_busy | sb_tmp;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic bz;
        int   acc0;
        logic [15:0] a, b;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 16'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_quotient", {16'd0, quotient}, 32'd0);
        chk("rst_remainder", {16'd0, remainder}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);

        // Directed cases, including the divide-by-zero and zero-dividend corners.
        do_div(16'd100, 16'd7, bz);
        do_div(16'hFFFF, 16'h0001, bz);
        do_div(16'hFFFF, 16'hFFFF, bz);
        do_div(16'h8000, 16'h0003, bz);
        do_div(16'd1234, 16'd0, bz);
        do_div(16'd9, 16'd3, bz);
        do_div(16'd0, 16'd5, bz);
        do_div(16'd5, 16'd9, bz);
`ifdef UNSIGNED_DIVIDER_EARLY_OUT_EN
        chk("early_busy", {31'd0, bz}, 32'd0);
`else
        chk("full_busy", {31'd0, bz}, 32'd1);
`endif

        // start held high: operands change mid-run, second accept lands in DONE.
        dividend = 16'd1000;
        divisor  = 16'd7;
        start    = 1'b1;
        acc0     = cyc + 1;
        push_exp(16'd1000, 16'd7, acc0);
        repeat (5) @(negedge clk);
        dividend = 16'd2000;
        divisor  = 16'd9;
        for (int i = 0; i < 40 && cyc < acc0 + 17; i++) @(negedge clk);
        chk("b2b_first_done", {31'd0, done}, 32'd1);
        push_exp(16'd2000, 16'd9, acc0 + 17);
        start = 1'b0;
        wait_done(bz);
        @(negedge clk);

        // Reset in the middle of a run: no done may follow.
        dividend = 16'd1000;
        divisor  = 16'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_quotient", {16'd0, quotient}, 32'd0);
        chk("midrst_remainder", {16'd0, remainder}, 32'd0);
        chk("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
        repeat (25) @(negedge clk);
        do_div(16'd50, 16'd5, bz);

        // Random pairs with biased divisors to hit zero, one and small values.
        for (int n = 0; n < 1500; n++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 4))
                0: b = 16'd0;
                1: b = 16'($urandom_range(1, 15));
                2: b = 16'($urandom_range(0, 1) ? 1 : 16'hFFFF);
                default: b = 16'($urandom);
            endcase
            do_div(a, b, bz);
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
